// File: rtl/qubit_state_classifier.sv
// qubit_state_classifier: normalizes an accumulated I/Q pair and evaluates a
// 2-16-1 network (ReLU hidden layer, hard-sigmoid output) on one multiplier.
// Optional build macro NORM_SAT_EN: saturate the normalized samples instead of
// keeping the low OUT_W bits.
module qubit_state_classifier #(
    parameter int IN_W       = 32,
    parameter int OUT_W      = 18,
    parameter int IN         = 35,
    parameter int DS         = 17,
    parameter int NORM_SHIFT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_trigger,
    input  logic [2*IN_W-1:0]       accumulated_data,
    input  logic signed [IN_W-1:0]  normalizer_min [2],
    input  logic signed [OUT_W-1:0] weight_bias [65],
    output logic                    idle,
    output logic                    ready,
    output logic [OUT_W-1:0]        inference_prob,
    output logic                    inference_state,
    output logic                    done_trigger
);

    localparam int DW = IN_W + 1;     // offset-subtracted sample width
    localparam int PW = 2 * OUT_W;    // product width
    localparam int AW = IN + 8;       // accumulator with headroom for 17 terms

    localparam logic signed [AW-1:0] IN_MAX_A  = {{(AW-IN+1){1'b0}}, {(IN-1){1'b1}}};
    localparam logic signed [AW-1:0] IN_MIN_A  = ~IN_MAX_A;
    localparam logic signed [AW-1:0] OUT_MAX_A = {{(AW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [AW-1:0] OUT_MIN_A = ~OUT_MAX_A;
    localparam logic signed [OUT_W+1:0] P_HALF = (OUT_W+2)'(2**(DS-1));
    localparam logic signed [OUT_W+1:0] P_ONE  = (OUT_W+2)'(2**DS);

    typedef enum logic [1:0] {S_IDLE, S_HID, S_OUT, S_FIN} state_t;

    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [AW-1:0] v);
        if (v > OUT_MAX_A) return OUT_MAX_A[OUT_W-1:0];
        if (v < OUT_MIN_A) return OUT_MIN_A[OUT_W-1:0];
        return v[OUT_W-1:0];
    endfunction

    function automatic logic signed [AW-1:0] sat_acc(input logic signed [AW-1:0] v);
        if (v > IN_MAX_A) return IN_MAX_A;
        if (v < IN_MIN_A) return IN_MIN_A;
        return v;
    endfunction

    // Accumulator -> activation: clamp to IN bits, drop DS fraction bits, clamp to OUT_W.
    function automatic logic signed [OUT_W-1:0] act(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] s;
        s = sat_acc(v) >>> DS;
        return sat_out(s);
    endfunction

    function automatic logic signed [OUT_W-1:0] norm_reduce(input logic signed [DW-1:0] d);
        logic signed [DW-1:0] s;
        s = d >>> NORM_SHIFT;
`ifdef NORM_SAT_EN
        return sat_out({{(AW-DW){s[DW-1]}}, s});
`else
        return s[OUT_W-1:0];
`endif
    endfunction

    function automatic logic signed [AW-1:0] bias_term(input logic signed [OUT_W-1:0] b);
        logic signed [AW-1:0] e;
        e = {{(AW-OUT_W){b[OUT_W-1]}}, b};
        return e <<< DS;
    endfunction

    // Hard sigmoid: 0.5 + z/4, clamped to [0, 1.0].
    function automatic logic [OUT_W-1:0] prob_of(input logic signed [OUT_W-1:0] z);
        logic signed [OUT_W-1:0] zq;
        logic signed [OUT_W+1:0] p;
        zq = z >>> 2;
        p  = $signed({{2{zq[OUT_W-1]}}, zq}) + P_HALF;
        if (p < 0) return '0;
        if (p > P_ONE) return P_ONE[OUT_W-1:0];
        return p[OUT_W-1:0];
    endfunction

    // Control state
    state_t state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d;
    logic done_q, done_d, st_q, st_d;
    logic [OUT_W-1:0] prob_q, prob_d;

    // Datapath state
    logic signed [DW-1:0]    d_i_p0_q, d_i_p0_d, d_q_p0_q, d_q_p0_d;
    logic signed [OUT_W-1:0] x_i_p1_q, x_i_p1_d, x_q_p1_q, x_q_p1_d;
    logic signed [AW-1:0]    acc_q, acc_d;
    logic signed [OUT_W-1:0] hidden_q [16];
    logic signed [OUT_W-1:0] hidden_d [16];

    logic                    accept;
    logic [6:0]              widx, bidx;
    logic signed [OUT_W-1:0] op_a, op_b;
    logic signed [PW-1:0]    prod;
    logic signed [AW-1:0]    prod_ext;
    logic signed [OUT_W-1:0] z_fin;

    assign idle   = (state_q == S_IDLE) && !vld_p0_q && !vld_p1_q;
    assign ready  = idle;
    assign accept = start_trigger && ready;

    assign d_i_p0_d = $signed({accumulated_data[IN_W-1], accumulated_data[IN_W-1:0]})
                    - $signed({normalizer_min[0][IN_W-1], normalizer_min[0]});
    assign d_q_p0_d = $signed({accumulated_data[2*IN_W-1], accumulated_data[2*IN_W-1:IN_W]})
                    - $signed({normalizer_min[1][IN_W-1], normalizer_min[1]});
    assign x_i_p1_d = norm_reduce(d_i_p0_q);
    assign x_q_p1_d = norm_reduce(d_q_p0_q);
    assign vld_p0_d = accept;
    assign vld_p1_d = vld_p0_q;

    // Shared multiplier operand selection: input x weight in HID, hidden x w2 in OUT.
    always_comb begin
        widx = {2'b00, cnt_q};
        bidx = 7'd32 + {3'b000, cnt_q[4:1]};
        op_a = cnt_q[0] ? x_q_p1_q : x_i_p1_q;
        if (state_q == S_OUT) begin
            widx = 7'd48 + {3'b000, cnt_q[3:0]};
            op_a = hidden_q[cnt_q[3:0]];
        end
        op_b = weight_bias[widx];
    end

    assign prod     = PW'(op_a) * PW'(op_b);
    assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
    assign z_fin    = act(acc_q);

    // Accumulate products; finish a hidden neuron on every second HID cycle.
    always_comb begin
        logic signed [AW-1:0]    hsum;
        logic signed [OUT_W-1:0] hact;
        acc_d    = acc_q;
        hidden_d = hidden_q;
        hsum     = acc_q + prod_ext;
        hact     = act(hsum);
        case (state_q)
            S_HID: begin
                if (!cnt_q[0]) begin
                    acc_d = bias_term(weight_bias[bidx]) + prod_ext;
                end else begin
                    hidden_d[cnt_q[4:1]] = hact[OUT_W-1] ? '0 : hact;
                end
            end
            S_OUT: begin
                acc_d = ((cnt_q[3:0] == 4'd0) ? bias_term(weight_bias[64]) : acc_q) + prod_ext;
            end
            default: ;
        endcase
    end

    // FSM next state, step counter and output register updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        prob_d  = prob_q;
        st_d    = st_q;
        case (state_q)
            S_IDLE: begin
                if (vld_p1_q) begin
                    state_d = S_HID;
                    cnt_d   = '0;
                end
            end
            S_HID: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_OUT;
                    cnt_d   = '0;
                end
            end
            S_OUT: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd15) begin
                    state_d = S_FIN;
                    cnt_d   = '0;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                prob_d  = prob_of(z_fin);
                st_d    = !z_fin[OUT_W-1];
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and output registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            done_q   <= 1'b0;
            prob_q   <= '0;
            st_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vld_p0_q <= vld_p0_d;
            vld_p1_q <= vld_p1_d;
            done_q   <= done_d;
            prob_q   <= prob_d;
            st_q     <= st_d;
        end
    end

    // Datapath registers; qualified by the valid/FSM state, never reset.
    always_ff @(posedge clk) begin
        // p0: offset subtraction
        if (accept) begin
            d_i_p0_q <= d_i_p0_d;
            d_q_p0_q <= d_q_p0_d;
        end
        // p1: shift and width reduction, held for the whole inference
        if (vld_p0_q) begin
            x_i_p1_q <= x_i_p1_d;
            x_q_p1_q <= x_q_p1_d;
        end
        acc_q    <= acc_d;
        hidden_q <= hidden_d;
    end

    assign inference_prob  = prob_q;
    assign inference_state = st_q;
    assign done_trigger    = done_q;

endmodule

// File: tb/tb_qubit_state_classifier.sv
// Directed, table-driven bench for qubit_state_classifier.
module tb_qubit_state_classifier;

    localparam int LAT   = 52;
    localparam int LIMIT = 200;
`ifdef NORM_SAT_EN
    localparam int SAT_P = 98303;
`else
    localparam int SAT_P = 65536;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start_trigger = 1'b0;
    logic [63:0]        accumulated_data = '0;
    logic signed [31:0] nmin [2];
    logic signed [17:0] wb [65];
    logic               idle, ready, inference_state, done_trigger;
    logic [17:0]        inference_prob;

    int checks = 0;
    int errors = 0;

    qubit_state_classifier dut (
        .clk              (clk),
        .rst              (rst),
        .start_trigger    (start_trigger),
        .accumulated_data (accumulated_data),
        .normalizer_min   (nmin),
        .weight_bias      (wb),
        .idle             (idle),
        .ready            (ready),
        .inference_prob   (inference_prob),
        .inference_state  (inference_state),
        .done_trigger     (done_trigger)
    );

    always #5 clk = ~clk;

    typedef struct {
        string              name;
        logic [63:0]        data;
        logic signed [31:0] mi, mq;
        int                 ia, ib;
        logic signed [17:0] va, vb;
        int                 ep;
        bit                 es;
    } vec_t;

    vec_t vt [$];

    task automatic add(input string nm, input logic [63:0] d, input logic signed [31:0] mi,
                       input logic signed [31:0] mq, input int ia, input logic signed [17:0] va,
                       input int ib, input logic signed [17:0] vb, input int ep, input bit es);
        vec_t v;
        v.name = nm; v.data = d; v.mi = mi; v.mq = mq;
        v.ia = ia; v.va = va; v.ib = ib; v.vb = vb; v.ep = ep; v.es = es;
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_weights();
        for (int k = 0; k < 65; k++) wb[k] = '0;
    endtask

    task automatic load_vec(input vec_t v);
        clear_weights();
        if (v.ia >= 0) wb[v.ia] = v.va;
        if (v.ib >= 0) wb[v.ib] = v.vb;
        accumulated_data = v.data;
        nmin[0] = v.mi;
        nmin[1] = v.mq;
    endtask

    // Pulse start for one cycle and count edges until done_trigger is seen.
    task automatic start_wait(output int n);
        start_trigger = 1'b1;
        step();
        start_trigger = 1'b0;
        n = 1;
        while (!done_trigger && n < LIMIT) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n, dones, first;
        nmin[0] = '0;
        nmin[1] = '0;
        clear_weights();

        add("zero_w",    64'h1234_5678_9ABC_DEF0, 0, 0, -1, 0, -1, 0, 65536, 1'b1);
        add("b2_max",    64'h0, 0, 0, 64, 18'sd131071, -1, 0, 98303, 1'b1);
        add("b2_min",    64'h0, 0, 0, 64, -18'sd131072, -1, 0, 32768, 1'b0);
        add("xi_pos",    64'h0000_0000_0100_0000, 0, 0, 0, 18'sd131071, 48, 18'sd131071, 81919, 1'b1);
        add("relu_cut",  64'h0000_0000_0100_0000, 0, 0, 0, -18'sd131072, 48, 18'sd131071, 65536, 1'b1);
        add("norm_top",  64'h0000_0000_7FFF_FFFF, 0, 0, 0, 18'sd131071, 48, 18'sd131071, SAT_P, 1'b1);
        add("i_offset",  64'h0, -32'sd16777216, 0, 0, 18'sd131071, 48, 18'sd131071, 81919, 1'b1);
        add("xq_pos",    64'h0100_0000_0000_0000, 0, 0, 1, 18'sd131071, 48, 18'sd131071, 81919, 1'b1);
        add("z_neg",     64'h0000_0000_0100_0000, 0, 0, 0, 18'sd131071, 48, -18'sd131072, 49152, 1'b0);
        add("b1_only",   64'h0000_0000_0100_0000, 0, 0, 32, 18'sd1000, 48, 18'sd131071, 65785, 1'b1);
        add("neuron15",  64'h0000_0000_0100_0000, 0, 0, 30, 18'sd131071, 63, 18'sd131071, 81919, 1'b1);
        add("q_off_h15", 64'h0, 0, -32'sd16777216, 31, 18'sd131071, 63, 18'sd131071, 81919, 1'b1);

        // Reset values, during and after reset
        step();
        chk("rst_idle", idle, 1);
        chk("rst_ready", ready, 1);
        chk("rst_prob", inference_prob, 0);
        chk("rst_state", inference_state, 0);
        chk("rst_done", done_trigger, 0);
        rst = 1'b1;
        step();
        chk("post_rst_idle", idle, 1);

        foreach (vt[i]) begin
            load_vec(vt[i]);
            start_wait(n);
            chk({vt[i].name, "_lat"}, n, LAT);
            chk({vt[i].name, "_prob"}, inference_prob, vt[i].ep);
            chk({vt[i].name, "_state"}, inference_state, vt[i].es);
            step();
            chk({vt[i].name, "_done_low"}, done_trigger, 0);
        end

        // Output accumulator saturates high, then low
        clear_weights();
        for (int k = 32; k < 64; k++) wb[k] = 18'sd131071;
        start_wait(n);
        chk("osat_hi_lat", n, LAT);
        chk("osat_hi_prob", inference_prob, 98303);
        for (int k = 48; k < 64; k++) wb[k] = -18'sd131072;
        step();
        start_wait(n);
        chk("osat_lo_prob", inference_prob, 32768);
        chk("osat_lo_state", inference_state, 0);

        // Start in the done cycle is accepted back to back
        clear_weights();
        wb[64] = 18'sd131071;
        chk("b2b_ready_at_done", ready, 1);
        start_wait(n);
        chk("b2b_lat", n, LAT);
        chk("b2b_prob", inference_prob, 98303);
        step();

        // A second start during an inference is ignored
        load_vec(vt[3]);
        start_trigger = 1'b1;
        step();
        start_trigger = 1'b0;
        n = 1;
        chk("busy_ready_c1", ready, 0);
        step();
        n++;
        chk("busy_idle_c2", idle, 0);
        while (n < 10) begin
            step();
            n++;
        end
        chk("busy_idle_c10", idle, 0);
        accumulated_data = 64'h0;
        start_trigger = 1'b1;
        step();
        n++;
        start_trigger = 1'b0;
        dones = 0;
        first = -1;
        while (n < 130) begin
            if (done_trigger) begin
                dones++;
                if (first < 0) first = n;
                chk("ign_prob", inference_prob, 81919);
            end
            step();
            n++;
        end
        chk("ign_dones", dones, 1);
        chk("ign_first", first, LAT);

        // Reset mid-inference aborts and clears outputs
        clear_weights();
        wb[64] = 18'sd131071;
        start_wait(n);
        chk("pre_rst_prob", inference_prob, 98303);
        step();
        start_trigger = 1'b1;
        step();
        start_trigger = 1'b0;
        for (int k = 1; k < 20; k++) step();
        rst = 1'b0;
        #1;
        chk("abort_prob", inference_prob, 0);
        chk("abort_state", inference_state, 0);
        chk("abort_done", done_trigger, 0);
        chk("abort_idle", idle, 1);
        chk("abort_ready", ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        dones = 0;
        for (int k = 0; k < 80; k++) begin
            step();
            if (done_trigger) dones++;
        end
        chk("abort_no_done", dones, 0);
        chk("abort_prob_hold", inference_prob, 0);
        start_wait(n);
        chk("after_abort_lat", n, LAT);
        chk("after_abort_prob", inference_prob, 98303);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
